// File: rtl/poly_eval_horner_if.sv
// Handshake bundle for poly_eval_horner: start/points in, coefficient memory
// port, GF32 multiplier port and packed results.
interface poly_eval_horner_if #(
  parameter int unsigned M = 230,
  parameter int unsigned T = 3
);
  localparam int unsigned ADDR_W = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned PW     = 32 * T;

  logic              start;
  logic [PW-1:0]     r;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic [7:0]        coef;
  logic              start_mul32;
  logic [31:0]       x_mul32;
  logic [31:0]       y_mul32;
  logic [31:0]       prod_mul32;
  logic              done_mul32;
  logic [PW-1:0]     evaluate;
  logic              done;
  logic              busy;

  // slave = the evaluation engine, master = whoever drives it
  modport slave (
    input  start, r, coef, prod_mul32, done_mul32,
    output addr, rd, start_mul32, x_mul32, y_mul32, evaluate, done, busy
  );

  modport master (
    output start, r, coef, prod_mul32, done_mul32,
    input  addr, rd, start_mul32, x_mul32, y_mul32, evaluate, done, busy
  );
endinterface

// File: rtl/poly_eval_horner.sv
// Horner evaluation of a byte-coefficient polynomial at T points of GF(2^32),
// sharing one external GF32 multiplier; one multiply outstanding at a time.
module poly_eval_horner #(
  parameter int unsigned M = 230,
  parameter int unsigned T = 3
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  poly_eval_horner_if.slave bus
);
  localparam int unsigned ADDR_W = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned JW     = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned PW     = 32 * T;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, MUL_START, MUL_WAIT, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k, k_nxt;
  logic [JW-1:0]     j, j_nxt;
  logic [PW-1:0]     r_reg, r_nxt;
  logic [PW-1:0]     acc, acc_nxt;
  logic [7:0]        coef_reg, coef_nxt;
  logic              rd_q, rd_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              start_mul_q, start_mul_nxt;
  logic [31:0]       x_q, x_nxt;
  logic [31:0]       y_q, y_nxt;
  logic              done_q, done_nxt;
  logic              busy_q, busy_nxt;

  // GF256 subfield embedding of a coefficient byte
  function automatic logic [31:0] lift(input logic [7:0] c);
    return {24'b0, c};
  endfunction

  // point 0 sits in the most significant lane
  function automatic int unsigned lane_lsb(input logic [JW-1:0] idx);
    return 32 * (T - 1 - 32'(idx));
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      k           <= '0;
      j           <= '0;
      r_reg       <= '0;
      acc         <= '0;
      coef_reg    <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      start_mul_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      j           <= j_nxt;
      r_reg       <= r_nxt;
      acc         <= acc_nxt;
      coef_reg    <= coef_nxt;
      rd_q        <= rd_nxt;
      addr_q      <= addr_nxt;
      start_mul_q <= start_mul_nxt;
      x_q         <= x_nxt;
      y_q         <= y_nxt;
      done_q      <= done_nxt;
      busy_q      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    j_nxt     = j;
    r_nxt     = r_reg;
    acc_nxt   = acc;
    coef_nxt  = coef_reg;

    case (state)
      IDLE: begin
        if (bus.start) begin
          r_nxt     = bus.r;
          k_nxt     = ADDR_W'(M - 1);
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        coef_nxt = bus.coef;
        if (k == ADDR_W'(M - 1)) begin
          // leading coefficient seeds every accumulator without a multiply
          acc_nxt = {T{lift(bus.coef)}};
          if (M == 1) begin
            state_nxt = DONE;
          end else begin
            k_nxt     = k - ADDR_W'(1);
            state_nxt = FETCH;
          end
        end else begin
          j_nxt     = '0;
          state_nxt = MUL_START;
        end
      end
      MUL_START: state_nxt = MUL_WAIT;
      MUL_WAIT: begin
        if (bus.done_mul32) begin
          acc_nxt[lane_lsb(j) +: 32] = bus.prod_mul32 ^ lift(coef_reg);
          if (j < JW'(T - 1)) begin
            j_nxt     = j + JW'(1);
            state_nxt = MUL_START;
          end else if (k == '0) begin
            state_nxt = DONE;
          end else begin
            k_nxt     = k - ADDR_W'(1);
            state_nxt = FETCH;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // outputs are registered, decoded from the state being entered
    rd_nxt        = (state_nxt == FETCH);
    addr_nxt      = rd_nxt ? k_nxt : addr_q;
    start_mul_nxt = (state_nxt == MUL_START);
    x_nxt         = start_mul_nxt ? acc_nxt[lane_lsb(j_nxt) +: 32] : x_q;
    y_nxt         = start_mul_nxt ? r_nxt[lane_lsb(j_nxt) +: 32] : y_q;
    done_nxt      = (state_nxt == DONE);
    busy_nxt      = (state_nxt != IDLE);
  end

  assign bus.addr        = addr_q;
  assign bus.rd          = rd_q;
  assign bus.start_mul32 = start_mul_q;
  assign bus.x_mul32     = x_q;
  assign bus.y_mul32     = y_q;
  assign bus.evaluate    = acc;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_poly_eval_horner.sv
// Directed bench for poly_eval_horner (M=4 and M=1, T=3) with a GF32
// multiplier model of programmable latency and a coefficient memory model.
module tb_poly_eval_horner;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  poly_eval_horner_if #(.M(4), .T(3)) b4 ();
  poly_eval_horner_if #(.M(1), .T(3)) b1 ();

  poly_eval_horner #(.M(4), .T(3)) u_dut  (.i_clk(clk), .i_rst_n(rst_n), .bus(b4));
  poly_eval_horner #(.M(1), .T(3)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] mem [4];
  logic [7:0] mem1;
  int         mul_lat = 1;
  int         mul_cnt;

  // GF(2^32) multiply, reduction polynomial x^32 + x^22 + x^2 + x + 1
  function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    logic [31:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[31] ? ((aa << 1) ^ 32'h0040_0007) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] horner(input logic [31:0] pt);
    logic [31:0] a;
    a = {24'b0, mem[3]};
    for (int k = 2; k >= 0; k--) a = gf_mul(a, pt) ^ {24'b0, mem[k]};
    return a;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // coefficient memory: data valid the cycle after rd
  always @(posedge clk) begin
    if (b4.rd) b4.coef <= mem[b4.addr];
    if (b1.rd) b1.coef <= mem1;
  end

  // multiplier model; product taken from the operands present at done time
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt       <= 0;
      b4.done_mul32 <= 1'b0;
      b4.prod_mul32 <= '0;
    end else begin
      b4.done_mul32 <= 1'b0;
      if (b4.start_mul32) begin
        if (mul_lat <= 1) begin
          b4.done_mul32 <= 1'b1;
          b4.prod_mul32 <= gf_mul(b4.x_mul32, b4.y_mul32);
        end else begin
          mul_cnt <= mul_lat - 1;
        end
      end else if (mul_cnt > 0) begin
        mul_cnt <= mul_cnt - 1;
        if (mul_cnt == 1) begin
          b4.done_mul32 <= 1'b1;
          b4.prod_mul32 <= gf_mul(b4.x_mul32, b4.y_mul32);
        end
      end
    end
  end

  assign b1.done_mul32 = 1'b0;
  assign b1.prod_mul32 = '0;

  logic [7:0]  addr_log;
  int          n_rd, n_mul, n_done, n_ovl;
  logic        prev_sm;
  logic [31:0] first_x, first_y;

  always @(negedge clk) begin
    if (b4.rd) begin
      addr_log = {addr_log[5:0], b4.addr};
      n_rd++;
    end
    if (b4.start_mul32) begin
      if (n_mul == 0) begin
        first_x = b4.x_mul32;
        first_y = b4.y_mul32;
      end
      n_mul++;
      if (prev_sm || mul_cnt > 0) n_ovl++;
    end
    prev_sm = b4.start_mul32;
    if (b4.done) n_done++;
  end

  task automatic clear_mon();
    n_rd = 0; n_mul = 0; n_done = 0; n_ovl = 0; addr_log = '0; prev_sm = 1'b0;
  endtask

  task automatic run(input string tag, input logic [95:0] r, input int lat,
                     input int exp_cyc, input int mid_at, input logic [95:0] exp_res);
    int cyc;
    mul_lat = lat;
    @(negedge clk);
    clear_mon();
    b4.r     = r;
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    b4.r     = ~r;
    cyc      = 1;
    while (!b4.done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      b4.start = (cyc == mid_at);
    end
    b4.start = 1'b0;
    check({tag, "_cycle"}, 128'(cyc), 128'(exp_cyc));
    check({tag, "_result"}, 128'(b4.evaluate), 128'(exp_res));
    @(negedge clk);
    check({tag, "_ndone"}, 128'(n_done), 128'd1);
    check({tag, "_nrd"}, 128'(n_rd), 128'd4);
    check({tag, "_addrs"}, 128'(addr_log), 128'hE4);
    check({tag, "_nmul"}, 128'(n_mul), 128'd9);
    check({tag, "_overlap"}, 128'(n_ovl), 128'd0);
    check({tag, "_stable"}, 128'(b4.evaluate), 128'(exp_res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] p0, p1, p2;
    int cyc1, nmul1, nrd1;

    rst_n    = 1'b0;
    b4.start = 1'b0;
    b4.r     = '0;
    b1.start = 1'b0;
    b1.r     = '0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    mem1 = 8'hA5;
    repeat (3) @(negedge clk);

    check("rst_rd",    128'(b4.rd), 128'd0);
    check("rst_addr",  128'(b4.addr), 128'd0);
    check("rst_smul",  128'(b4.start_mul32), 128'd0);
    check("rst_x",     128'(b4.x_mul32), 128'd0);
    check("rst_y",     128'(b4.y_mul32), 128'd0);
    check("rst_eval",  128'(b4.evaluate), 128'd0);
    check("rst_done",  128'(b4.done), 128'd0);
    check("rst_busy",  128'(b4.busy), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // all-zero coefficients
    run("zero", {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001}, 1, 27, 0, 96'h0);

    // {1,2,4,8} at r=1 sums to 0xF
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
    run("ones", {3{32'h0000_0001}}, 1, 27, 0, {3{32'h0000_000F}});

    // r=0 leaves only c_0; first multiply operands are c_3 and 0
    run("rzero", {3{32'h0000_0000}}, 1, 27, 0, {3{32'h0000_0001}});
    check("rzero_first_x", 128'(first_x), 128'h8);
    check("rzero_first_y", 128'(first_y), 128'h0);

    // hand vector, L=5, with a start pulse mid-run
    mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h05; mem[3] = 8'hFF;
    p2 = horner(32'h8000_0000);
    run("hand", {32'h0000_0002, 32'h0000_0100, 32'h8000_0000}, 5, 63, 20,
        {32'h0000_07EB, 32'hFF05_0301, p2});

    // pseudo-random coefficients and points, L=3
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    p0 = $urandom; p1 = $urandom; p2 = $urandom;
    run("rand", {p0, p1, p2}, 3, 45, 0, {horner(p0), horner(p1), horner(p2)});

    // reset in the middle of MUL_WAIT
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
    mul_lat = 5;
    @(negedge clk);
    clear_mon();
    b4.r     = {3{32'h0000_0001}};
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    for (int i = 0; i < 50 && !b4.start_mul32; i++) @(negedge clk);
    check("abort_saw_mul", 128'(b4.start_mul32), 128'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(b4.busy), 128'd0);
    check("abort_rd",   128'(b4.rd), 128'd0);
    check("abort_smul", 128'(b4.start_mul32), 128'd0);
    check("abort_x",    128'(b4.x_mul32), 128'd0);
    check("abort_y",    128'(b4.y_mul32), 128'd0);
    check("abort_eval", 128'(b4.evaluate), 128'd0);
    check("abort_done", 128'(b4.done), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_nodone", 128'(n_done), 128'd0);
    run("post_rst", {3{32'h0000_0001}}, 1, 27, 0, {3{32'h0000_000F}});

    // single-coefficient instance
    @(negedge clk);
    b1.r     = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    b1.start = 1'b1;
    nmul1 = 0;
    nrd1  = 0;
    @(negedge clk);
    b1.start = 1'b0;
    cyc1 = 1;
    if (b1.rd) nrd1++;
    while (!b1.done && cyc1 < 20) begin
      @(negedge clk);
      cyc1++;
      if (b1.start_mul32) nmul1++;
      if (b1.rd) nrd1++;
    end
    check("m1_cycle",  128'(cyc1), 128'd3);
    check("m1_result", 128'(b1.evaluate), {32'h0, {3{32'h0000_00A5}}});
    check("m1_nmul",   128'(nmul1), 128'd0);
    check("m1_nrd",    128'(nrd1), 128'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/poly_eval_horner.md
# poly_eval_horner

Evaluates one byte-coefficient polynomial, stored in an external coefficient memory, at T points of GF(2^32) in parallel using Horner's rule. It returns all T evaluations as one packed word. This block is the evaluation engine directly upstream of the plain-broadcast stage, and is run twice per broadcast: once on the Q polynomial and once on the S polynomial. Its result feeds the alpha/beta computation through the existing start/done handshake. Multiplication is delegated to the shared GF32 multiplier through its start/done port.

## Interface
- M, 230: number of coefficients; degree is M-1.
- T, 3: number of evaluation points.
- ADDR_W, `CLOG2(M)`: coefficient address width.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- i_start  in  1  start pulse; accepted only in IDLE.
- i_r  in  32*T  evaluation points; sampled on the accepting i_start. Point j occupies bits [32*(T-j)-1 : 32*(T-j-1)].
- o_addr  out  ADDR_W  coefficient read address.
- o_rd  out  1  coefficient read strobe.
- i_coef  in  8  coefficient byte; valid exactly 1 cycle after o_rd.
- o_start_mul32  out  1  one-cycle pulse to the GF32 multiplier.
- o_x_mul32, o_y_mul32  out  32  multiplier operands (accumulator, point).
- i_o_mul32  in  32  multiplier product; valid with i_done_mul32.
- i_done_mul32  in  1  multiplier done pulse.
- o_evaluate_out  out  32*T  results; same packing as i_r.
- o_done  out  1  one-cycle completion pulse.
- o_busy  out  1  high whenever state is not IDLE.

## Operation
- Coefficient k is stored at address k. Evaluation uses acc = acc·r + c_k for k = M-1 down to 0.
- Byte lift: a coefficient c becomes {24'b0, c} in GF(2^32), the GF256 subfield embedding. Addition is bitwise XOR.
- The first coefficient (k = M-1) is loaded directly into every accumulator, with no multiply. Consequently (M-1)·T multiplies are performed in total.
- State machine:
  - IDLE: on i_start, latch i_r into r_reg, set k = M-1, go to FETCH.
  - FETCH: drive o_rd=1 and o_addr=k; go to LOAD.
  - LOAD: latch i_coef into coef_reg.
    - If k = M-1: set acc_j = lift(i_coef) for all j. Then, if M = 1, go to DONE; otherwise k--, go to FETCH.
    - Otherwise: set j = 0, go to MUL_START.
  - MUL_START: drive o_start_mul32=1, o_x_mul32=acc_j, o_y_mul32=r_j; go to MUL_WAIT.
  - MUL_WAIT: hold the operands. On i_done_mul32, set acc_j ← i_o_mul32 ^ lift(coef_reg), then:
    - if j < T-1: j++, go to MUL_START;
    - else if k = 0: go to DONE;
    - else: k--, go to FETCH.
  - DONE: o_done=1 for one cycle; go to IDLE.
- o_evaluate_out is the accumulator register. It is stable from o_done until the LOAD of the next run's first coefficient.
- i_start while busy: ignored.
- i_done_mul32 outside MUL_WAIT: ignored.
- i_r changes after the accepting i_start: no effect.

## Timing
- Reset values: o_rd=0, o_addr=0, o_start_mul32=0, o_x_mul32=0, o_y_mul32=0, o_evaluate_out=0, o_done=0, o_busy=0. State returns to IDLE immediately on assertion of i_rst_n low; this also holds mid-run, and no o_done is produced for an aborted run.
- Multiplier latency L ≥ 1: i_done_mul32 arrives L cycles after o_start_mul32. Each point therefore costs L+1 cycles.
- Total latency: o_done is high in cycle 2M + (M-1)·T·(L+1) + 1, counting the cycle after the accepting i_start as cycle 1.
- o_rd is high for exactly M cycles per run, with addresses strictly descending M-1 … 0.
- o_start_mul32 is never high on two consecutive cycles. At most one multiply is outstanding at any time.
- A new i_start is accepted in the cycle after DONE (IDLE).

## Test plan
All scenarios use M=4, T=3, with a bench GF32 multiplier model at L=1 unless stated.
- All coefficients 0x00, any points → o_evaluate_out = 0. o_done in cycle 27; o_rd asserted 4 times with addresses 3, 2, 1, 0.
- Coefficients {0x01, 0x02, 0x04, 0x08} with all r_j = 0x00000001 → each point = 0x0000000F.
- Same coefficients with r_j = 0 → each point = 0x00000001 (c_0 only). Verify mul operands in the first MUL_START: x = 0x00000008, y = 0.
- Random coefficients and points, checked against a Horner model using the codebase GF32 multiply. Repeat with L=5: o_done in cycle 8 + 9·6 + 1 = 63. Apply a second i_start mid-run; it must be ignored.
- Drop i_rst_n in the middle of MUL_WAIT → all outputs return to 0 at once, with no o_done. A fresh start then yields the correct result.
- M=1, coefficient 0xA5 → all points = 0x000000A5. No o_start_mul32 is issued; o_done in cycle 3.
